// File: rtl/student_iic_master_seq.sv
// Byte-level I2C master sequencer: START/STOP/WRITE/READ commands
// turned into open-drain SDA/SCL timing built from quarter-bit ticks.
module student_iic_master_seq #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic [7:0] wdata_i,
    input  logic       rd_nack_i,
    output logic       rsp_valid_o,
    output logic [7:0] rdata_o,
    output logic       ack_o,
    output logic       err_o,
    output logic       busy_o,
    output logic       sda_oe_o,
    output logic       scl_oe_o,
    input  logic       sda_i,
    input  logic       scl_i
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_RESP
    } state_t;

    state_t state, state_n;

    logic [CW-1:0] cnt;
    logic [1:0]    qtr;
    logic [3:0]    idx;
    logic          is_read;
    logic [7:0]    wbyte;
    logic          nack;
    logic [7:0]    shreg;
    logic [7:0]    rdata;
    logic          ack;
    logic          err;
    logic          owned;

    logic accept;
    logic active;
    logic hold;
    logic tick;
    logic last_q;
    logic bitval;
    logic arb_lost;

    assign accept = cmd_valid_i && (state == S_IDLE);
    assign active = (state == S_START) || (state == S_BIT) || (state == S_STOP);
    // Q1 is the wait-high quarter: a slave holding SCL low freezes the count
    assign hold   = (qtr == 2'd1) && !scl_i;
    assign tick   = active && !hold && (cnt == LAST);
    assign last_q = tick && (qtr == 2'd3);

    always_comb begin
        bitval = 1'b1;
        if (idx[3]) begin
            bitval = is_read ? nack : 1'b1;
        end else if (!is_read) begin
            bitval = wbyte[7];
        end
    end

    assign arb_lost = (state == S_BIT) && tick && (qtr == 2'd2) &&
                      !is_read && !idx[3] && wbyte[7] && !sda_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        sda_oe_o = 1'b0;
        scl_oe_o = owned;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_i == CMD_START) begin
                        state_n = S_START;
                    end else if (!owned) begin
                        state_n = S_RESP;
                    end else if (cmd_i == CMD_STOP) begin
                        state_n = S_STOP;
                    end else begin
                        state_n = S_BIT;
                    end
                end
            end
            S_START: begin
                sda_oe_o = qtr[1];
                scl_oe_o = (qtr == 2'd0) ? owned : (qtr == 2'd3);
                if (last_q) begin
                    state_n = S_RESP;
                end
            end
            S_BIT: begin
                sda_oe_o = ~bitval;
                scl_oe_o = (qtr == 2'd0) || (qtr == 2'd3);
                if (arb_lost) begin
                    state_n = S_RESP;
                end else if (last_q && (idx == 4'd8)) begin
                    state_n = S_RESP;
                end
            end
            S_STOP: begin
                sda_oe_o = ~qtr[1];
                scl_oe_o = (qtr == 2'd0);
                if (last_q) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt     <= '0;
            qtr     <= 2'd0;
            idx     <= 4'd0;
            is_read <= 1'b0;
            wbyte   <= 8'h00;
            nack    <= 1'b0;
            shreg   <= 8'h00;
            rdata   <= 8'h00;
            ack     <= 1'b0;
            err     <= 1'b0;
            owned   <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            qtr     <= 2'd0;
            idx     <= 4'd0;
            is_read <= (cmd_i == CMD_READ);
            wbyte   <= wdata_i;
            nack    <= rd_nack_i;
            ack     <= 1'b0;
            err     <= (cmd_i != CMD_START) && !owned;
        end else if (active) begin
            if (hold || (cnt == LAST)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (tick) begin
                qtr <= qtr + 2'd1;
            end
            if (tick && (qtr == 2'd2) && (state == S_BIT)) begin
                if (!idx[3]) begin
                    shreg <= {shreg[6:0], sda_i};
                end else if (is_read) begin
                    rdata <= shreg;
                end else begin
                    ack <= ~sda_i;
                end
            end
            if (last_q && (state == S_BIT)) begin
                idx   <= idx + 4'd1;
                wbyte <= {wbyte[6:0], 1'b0};
            end
            if (last_q && (state == S_START)) begin
                owned <= 1'b1;
            end
            if (last_q && (state == S_STOP)) begin
                owned <= 1'b0;
            end
            if (arb_lost) begin
                owned <= 1'b0;
                err   <= 1'b1;
                ack   <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = (state == S_IDLE);
    assign rsp_valid_o = (state == S_RESP);
    assign rdata_o     = rdata;
    assign ack_o       = ack;
    assign err_o       = err;
    assign busy_o      = owned;

endmodule

// File: tb/tb_student_iic_master_seq.sv
// Bench for student_iic_master_seq: pull-up bus, behavioural slave,
// directed vector table plus randomized commands against a command-level model.
module tb_student_iic_master_seq;

    localparam int C = 4;

    logic       clk;
    logic       rst_ni;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       rd_nack;
    logic       rsp_valid;
    logic [7:0] rdata;
    logic       ack;
    logic       err;
    logic       busy;
    logic       sda_oe;
    logic       scl_oe;
    logic       sda;
    logic       scl;

    student_iic_master_seq #(.CLK_DIV(C)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_i      (cmd),
        .wdata_i    (wdata),
        .rd_nack_i  (rd_nack),
        .rsp_valid_o(rsp_valid),
        .rdata_o    (rdata),
        .ack_o      (ack),
        .err_o      (err),
        .busy_o     (busy),
        .sda_oe_o   (sda_oe),
        .scl_oe_o   (scl_oe),
        .sda_i      (sda),
        .scl_i      (scl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave and bus state: mode 0 = passive, 1 = ACK a write, 2 = return sbyte
    int       mode;
    logic [7:0] sbyte;
    int       nfall;
    int       stretch_len;
    int       stretch_cnt;
    logic     comp_low;
    logic     slave_low;
    bit       sc_prev;
    bit       sd_prev;
    bit       oe_prev;
    bit       stop_seen;
    bit       oe_seen;
    bit       rises[$];

    assign slave_low = (mode == 1 && nfall == 8) ||
                       (mode == 2 && nfall < 8 && !sbyte[3'(7 - nfall)]);
    assign sda = !sda_oe && !slave_low && !comp_low;
    assign scl = !scl_oe && (stretch_cnt == 0);

    always @(negedge clk) begin
        bit sc;
        bit sd;
        if (stretch_cnt > 0) stretch_cnt--;
        if (!scl_oe && oe_prev && nfall == 3 && stretch_len > 0) begin
            stretch_cnt = stretch_len;
            stretch_len = 0;
        end
        oe_prev = scl_oe;
        sc = !scl_oe && (stretch_cnt == 0);
        sd = !sda_oe && !slave_low && !comp_low;
        if (sc && !sc_prev) rises.push_back(sd);
        if (!sc && sc_prev) nfall++;
        if (sc && sc_prev && sd && !sd_prev) stop_seen = 1;
        if (sda_oe || scl_oe) oe_seen = 1;
        sc_prev = sc;
        sd_prev = sd;
    end

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] wdata;
        logic       nack;
        logic       sack;
        logic [7:0] sbyte;
        int         stretch;
        logic       comp;
        int         lat;
        logic       err;
        logic       ack;
        logic [7:0] rdata;
        logic       busy;
    } vec_t;

    vec_t vq[$];
    int   n_cmp;
    int   n_bad;
    bit   m_owned;
    logic [7:0] m_rd;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] c, input logic [7:0] w,
                                input logic nk, input logic sk,
                                input logic [7:0] sb, input int st,
                                input logic cp, input int lat,
                                input logic e, input logic a,
                                input logic [7:0] rd, input logic b);
        vec_t v;
        v.cmd = c; v.wdata = w; v.nack = nk; v.sack = sk; v.sbyte = sb;
        v.stretch = st; v.comp = cp; v.lat = lat; v.err = e; v.ack = a;
        v.rdata = rd; v.busy = b;
        return v;
    endfunction

    // Command-level reference: latency from bit/quarter counts, ownership rules
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit found;
        int k;
        r = v;
        r.err = 0;
        r.ack = 0;
        found = 0;
        k = 0;
        if (v.cmd == 2'd0) begin
            r.lat = 4 * C + 1;
            m_owned = 1;
        end else if (!m_owned) begin
            r.lat = 1;
            r.err = 1;
        end else if (v.cmd == 2'd1) begin
            r.lat = 4 * C + 1;
            m_owned = 0;
        end else begin
            r.lat = 36 * C + 1 + v.stretch;
            if (v.cmd == 2'd2) begin
                r.ack = v.sack;
                for (int i = 0; i < 8; i++) begin
                    if (v.comp && !found && v.wdata[7 - i]) begin
                        found = 1;
                        k = i;
                    end
                end
                if (found) begin
                    r.lat = 4 * C * k + 3 * C + 1;
                    r.err = 1;
                    r.ack = 0;
                    m_owned = 0;
                end
            end else begin
                m_rd = v.sbyte;
            end
        end
        r.rdata = m_rd;
        r.busy = m_owned;
        return r;
    endfunction

    task automatic apply(input vec_t v, input int id);
        int n;
        bit got;
        logic [8:0] bv;
        logic [8:0] ev;
        string tag;
        tag = $sformatf("v%0d", id);
        @(posedge clk);
        #1;
        check({tag, "_ready_in"}, cmd_ready, 1);
        cmd_valid = 1;
        cmd = v.cmd;
        wdata = v.wdata;
        rd_nack = v.nack;
        mode = (v.cmd == 2'd2 && v.sack) ? 1 : (v.cmd == 2'd3) ? 2 : 0;
        sbyte = v.sbyte;
        nfall = 0;
        rises.delete();
        stretch_len = v.stretch;
        comp_low = v.comp;
        stop_seen = 0;
        oe_seen = 0;
        @(posedge clk);
        n = 0;
        got = 0;
        while (!got && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                cmd_valid = 0;
                if (v.lat > 1) check({tag, "_ready_busy"}, cmd_ready, 0);
            end
            if (rsp_valid) got = 1;
        end
        check({tag, "_latency"}, n, v.lat);
        check({tag, "_err"}, err, v.err);
        check({tag, "_busy"}, busy, v.busy);
        check({tag, "_rdata"}, rdata, v.rdata);
        if (v.cmd == 2'd2) check({tag, "_ack"}, ack, v.ack);
        if (v.err) check({tag, "_oe_rsp"}, {sda_oe, scl_oe}, 2'b00);
        if (v.err && v.lat == 1) check({tag, "_no_activity"}, oe_seen, 0);
        if (v.cmd == 2'd1 && !v.err) check({tag, "_stop_cond"}, stop_seen, 1);
        if (v.cmd[1] && !v.err) begin
            check({tag, "_nbits"}, rises.size(), 9);
            bv = '0;
            for (int i = 0; i < 9 && i < rises.size(); i++) bv[8 - i] = rises[i];
            ev = (v.cmd == 2'd2) ? {v.wdata, ~v.sack} : {v.sbyte, v.nack};
            check({tag, "_bus_bits"}, bv, ev);
        end
        comp_low = 0;
        mode = 0;
        @(negedge clk);
        check({tag, "_ready_out"}, cmd_ready, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mode = 0;
        sbyte = 8'h00;
        nfall = 0;
        stretch_len = 0;
        stretch_cnt = 0;
        comp_low = 0;
        sc_prev = 1;
        sd_prev = 1;
        oe_prev = 0;
        rst_ni = 0;
        cmd_valid = 0;
        cmd = 2'd0;
        wdata = 8'h00;
        rd_nack = 0;

        // cmd: 0 START, 1 STOP, 2 WRITE, 3 READ
        //          cmd   wdata  nk sk sbyte  st  cp lat  e  a  rdata  b
        vq.push_back(mk(2'd0, 8'h00, 0, 0, 8'h00, 0, 0, 17, 0, 0, 8'h00, 1));
        vq.push_back(mk(2'd2, 8'hA5, 0, 1, 8'h00, 0, 0, 145, 0, 1, 8'h00, 1));
        vq.push_back(mk(2'd3, 8'h00, 1, 0, 8'h3C, 0, 0, 145, 0, 0, 8'h3C, 1));
        vq.push_back(mk(2'd1, 8'h00, 0, 0, 8'h00, 0, 0, 17, 0, 0, 8'h3C, 0));
        vq.push_back(mk(2'd2, 8'h00, 0, 1, 8'h00, 0, 0, 1, 1, 0, 8'h3C, 0));
        vq.push_back(mk(2'd0, 8'h00, 0, 0, 8'h00, 0, 0, 17, 0, 0, 8'h3C, 1));
        vq.push_back(mk(2'd2, 8'h00, 0, 1, 8'h00, 50, 0, 195, 0, 1, 8'h3C, 1));
        vq.push_back(mk(2'd2, 8'h80, 0, 0, 8'h00, 0, 1, 13, 1, 0, 8'h3C, 0));
        vq.push_back(mk(2'd0, 8'h00, 0, 0, 8'h00, 0, 0, 17, 0, 0, 8'h3C, 1));
        vq.push_back(mk(2'd2, 8'h5A, 0, 0, 8'h00, 0, 0, 145, 0, 0, 8'h3C, 1));
        vq.push_back(mk(2'd3, 8'h00, 0, 0, 8'hC3, 0, 0, 145, 0, 0, 8'hC3, 1));
        vq.push_back(mk(2'd0, 8'h00, 0, 0, 8'h00, 0, 0, 17, 0, 0, 8'hC3, 1));
        vq.push_back(mk(2'd1, 8'h00, 0, 0, 8'h00, 0, 0, 17, 0, 0, 8'hC3, 0));
        vq.push_back(mk(2'd1, 8'h00, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'hC3, 0));
        vq.push_back(mk(2'd3, 8'h00, 0, 0, 8'h55, 0, 0, 1, 1, 0, 8'hC3, 0));

        m_owned = 0;
        m_rd = 8'hC3;
        vq.push_back(model(mk(2'd0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0)));
        for (int i = 0; i < 16; i++) begin
            logic [1:0] c;
            int st;
            c = 2'd2 + 2'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            vq.push_back(model(mk(c, 8'($urandom), 1'($urandom), 1'($urandom),
                                  8'($urandom), st, 0, 0, 0, 0, 8'h00, 0)));
        end
        vq.push_back(model(mk(2'd1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0)));
        vq.push_back(model(mk(2'd0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0)));
        vq.push_back(model(mk(2'd2, 8'h24, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0)));

        repeat (3) @(posedge clk);
        #1;
        check("rst_oe", {sda_oe, scl_oe}, 2'b00);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp", {rsp_valid, err, ack}, 3'b000);
        check("rst_rdata", rdata, 8'h00);
        rst_ni = 1;

        foreach (vq[i]) apply(vq[i], i);

        // Asynchronous reset in the middle of a WRITE
        apply(mk(2'd0, 8'h00, 0, 0, 8'h00, 0, 0, 17, 0, 0, m_rd, 1), 99);
        @(posedge clk);
        #1;
        cmd_valid = 1;
        cmd = 2'd2;
        wdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("mid_write_oe", {sda_oe, scl_oe}, 2'b11);
        #1;
        rst_ni = 0;
        #1;
        check("async_rst_oe", {sda_oe, scl_oe}, 2'b00);
        check("async_rst_ready", cmd_ready, 1);
        check("async_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_ni = 1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
